pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Two-client arbiter between the instruction cache and the data cache physical-memory ports, and the single downstream line-granular memory port (cacheline adaptor to DRAM).
- Accepts 256-bit line read requests from the icache, and 256-bit line read or write-back requests from the dcache.
- Serialises them with round-robin priority and routes the response back to the granted client.
- Latches the address and write data at grant, so the downstream port sees stable values for the whole transaction.

Parameters:
- LINE_W, 256, cache line width in bits (data buses).
- ADDR_W, 32, physical address width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  icache line read request, level, held until i_pmem_resp
- i_pmem_address  in  ADDR_W  icache line address, 32-byte aligned
- i_pmem_rdata  out  LINE_W  line returned to icache
- i_pmem_resp  out  1  one-cycle completion pulse to icache
- d_pmem_read  in  1  dcache line fill request, level, held until d_pmem_resp
- d_pmem_write  in  1  dcache write-back request, level, held until d_pmem_resp
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache write-back line
- d_pmem_rdata  out  LINE_W  line returned to dcache
- d_pmem_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_address  out  ADDR_W  latched granted address
- mem_wdata  out  LINE_W  latched granted write data
- mem_rdata  in  LINE_W  downstream read data, valid with mem_resp
- mem_resp  in  1  downstream completion, one cycle

Behaviour:
- Reset behaviour:
  - The synchronous reset (rst=1 at a rising edge) forces the FSM to IDLE and clears all latches, and sets last_grant=D.
  - This guarantees the icache wins the first tie.
  - While in reset/IDLE, all outputs are 0: mem_read, mem_write, mem_address, mem_wdata, both resp pulses, and both rdata buses.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Samples requests. i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
  - Only i_req: go to SERVE_I. Only d_req: go to SERVE_D.
  - Both: grant the client that is not last_grant.
  - On the grant edge:
    - Latch the address.
    - For D, latch wdata and the operation type. Write takes precedence if d_pmem_read and d_pmem_write are both high; that case is illegal, and the bench flags it.
    - Update last_grant.
  - Neither: stay in IDLE.
- SERVE_I / SERVE_D:
  - Assert mem_read (or mem_write for a D write) continuously until mem_resp. Address and wdata come from the latches, not the live inputs.
- Response cycle (mem_resp=1):
  - The granted client's resp is 1 combinationally in the same cycle.
  - The granted client's rdata equals mem_rdata in that cycle; otherwise it is 0.
  - The FSM returns to IDLE on that edge, and strobes drop in the next cycle.
  - The non-granted client never sees resp.
- Latency: a request in IDLE at cycle 0 gives a strobe from cycle 1. mem_resp at cycle k gives client resp at k, IDLE at k+1, and the earliest next strobe at k+2.
  - The mandatory IDLE bubble lets clients drop their level request after resp, so no phantom re-grant occurs.
- A client request that changes address mid-transaction has no effect; the latched values are used.
- mem_resp while in IDLE is ignored and produces no client resp.
- Dropping the request mid-transaction is illegal; the arbiter still completes the downstream transaction and pulses resp.
- A pending loser is served immediately after the current transaction, so there is no starvation. Worst-case wait is one transaction plus one bubble.
- Reset mid-transaction: the FSM returns to IDLE the next cycle and strobes drop. Any in-flight downstream response is discarded.

Test Plan:
- Single icache read:
  - Stimulus: i_pmem_read=1, addr 0x0000_1000, in IDLE; mem_resp after 3 cycles with rdata 0xA5 repeated.
  - Required: mem_read=1 from cycle 1 with mem_address=0x1000; i_pmem_resp pulses 1 cycle with i_pmem_rdata=pattern; d_pmem_resp stays 0.
- Dcache write-back:
  - Stimulus: d_pmem_write=1, addr 0x0000_2020, wdata=0xDEAD... .
  - Required: mem_write=1, mem_read=0, mem_wdata matches; d_pmem_resp on mem_resp.
- Simultaneous requests after reset:
  - Stimulus: i_pmem_read and d_pmem_read both high.
  - Required: I is served first, then D at resp+2; a second tie goes to I again (D was last served).
- Address stability:
  - Stimulus: change d_pmem_address to 0xFFFF_FFE0 mid-transaction.
  - Required: mem_address stays at the originally granted value until resp.
- Stray response in IDLE:
  - Stimulus: mem_resp=1 with no requests.
  - Required: no client resp, state stays IDLE.
- Reset mid-transaction:
  - Stimulus: rst=1 during SERVE_D.
  - Required: next cycle mem_read=mem_write=0, all outputs 0; a post-reset tie grants I.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter of icache/dcache line requests onto one memory port
module pmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state, state_n;
  logic last_d, wr_q, i_req, d_req, grant_i, grant_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign grant_i = state == IDLE && i_req && (!d_req || last_d);
  assign grant_d = state == IDLE && d_req && !grant_i;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // latch the granted request so the downstream port sees stable values
  always_ff @(posedge clk)
    if (rst) begin
      last_d  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_i) begin
      last_d  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= i_pmem_address;
      wdata_q <= '0;
    end else if (grant_d) begin
      last_d  <= 1'b1;
      wr_q    <= d_pmem_write;
      addr_q  <= d_pmem_address;
      wdata_q <= d_pmem_write ? d_pmem_wdata : '0;
    end
  // next state: grant from IDLE, return to IDLE on the response
  always_comb
    state_n = state == IDLE ? (grant_i ? SERVE_I : grant_d ? SERVE_D : IDLE)
                            : (mem_resp ? IDLE : state);
  // outputs: everything zero in IDLE, response routed only to the granted client
  always_comb begin
    mem_read     = state == SERVE_I || (state == SERVE_D && !wr_q);
    mem_write    = state == SERVE_D && wr_q;
    mem_address  = state == IDLE ? '0 : addr_q;
    mem_wdata    = state == IDLE ? '0 : wdata_q;
    i_pmem_resp  = state == SERVE_I && mem_resp;
    d_pmem_resp  = state == SERVE_D && mem_resp;
    i_pmem_rdata = (state == SERVE_I && mem_resp) ? mem_rdata : '0;
    d_pmem_rdata = (state == SERVE_D && mem_resp) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: scoreboard bench for the icache/dcache memory arbiter
module tb_pmem_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic i_pmem_read = 0, d_pmem_read = 0, d_pmem_write = 0, mem_resp = 0;
  logic [31:0] i_pmem_address = '0, d_pmem_address = '0, mem_address;
  logic [255:0] d_pmem_wdata = '0, mem_rdata = '0;
  logic [255:0] i_pmem_rdata, d_pmem_rdata, mem_wdata;
  logic i_pmem_resp, d_pmem_resp, mem_read, mem_write;

  typedef struct {
    logic d;
    logic wr;
    logic [31:0] addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // scoreboard: every client response must match the oldest expected transaction
  always @(negedge clk) begin : mon
    exp_t e;
    logic [255:0] got_rd, other_rd;
    if (d_pmem_read && d_pmem_write) begin
      errors++;
      $display("FAIL illegal_dreq read and write both high");
    end
    if (i_pmem_resp || d_pmem_resp) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp i=%0b d=%0b expected none", i_pmem_resp, d_pmem_resp);
      end else begin
        e = exp_q.pop_front();
        got_rd   = e.d ? d_pmem_rdata : i_pmem_rdata;
        other_rd = e.d ? i_pmem_rdata : d_pmem_rdata;
        if ({d_pmem_resp, i_pmem_resp} !== {e.d, !e.d} || mem_address !== e.addr ||
            mem_write !== e.wr || mem_read !== !e.wr || (e.wr && mem_wdata !== e.wdata) ||
            got_rd !== e.rdata || other_rd !== '0) begin
          errors++;
          $display("FAIL resp_txn got d=%0b i=%0b addr=%h wr=%0b rd=%0b rdata=%h want d=%0b addr=%h wr=%0b rdata=%h",
                   d_pmem_resp, i_pmem_resp, mem_address, mem_write, mem_read, got_rd[31:0],
                   e.d, e.addr, e.wr, e.rdata[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for a strobe, wait lat cycles, then return one response
  task automatic respond(input int lat, input logic [255:0] rd);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL strobe_timeout got no strobe after %0d cycles want strobe", n);
    end
    repeat (lat) tick();
    mem_rdata = rd;
    mem_resp  = 1;
    tick();
    mem_resp  = 0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000", {mem_read, mem_write, i_pmem_resp, d_pmem_resp});
    end
    checks++;
    if (mem_address !== '0 || mem_wdata !== '0 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
      errors++;
      $display("FAIL reset_buses got addr=%h wdata=%h want 0", mem_address, mem_wdata[31:0]);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_icache_read();
    logic [255:0] pat = {32{8'hA5}};
    i_pmem_read = 1;
    i_pmem_address = 32'h0000_1000;
    exp_q.push_back('{1'b0, 1'b0, 32'h0000_1000, 256'd0, pat});
    tick();
    checks++;
    if (mem_read !== 1 || mem_write !== 0 || mem_address !== 32'h0000_1000) begin
      errors++;
      $display("FAIL iread_strobe got rd=%0b wr=%0b addr=%h want 1 0 00001000", mem_read, mem_write, mem_address);
    end
    respond(2, pat);
    i_pmem_read = 0;
    checks++;
    if (mem_read !== 0 || i_pmem_resp !== 0) begin
      errors++;
      $display("FAIL iread_bubble got rd=%0b resp=%0b want 0 0", mem_read, i_pmem_resp);
    end
  endtask

  task automatic test_dcache_write();
    logic [255:0] wd = {8{32'hDEAD_BEEF}};
    logic [255:0] rd = {32{8'h3C}};
    tick();
    d_pmem_write = 1;
    d_pmem_address = 32'h0000_2020;
    d_pmem_wdata = wd;
    exp_q.push_back('{1'b1, 1'b1, 32'h0000_2020, wd, rd});
    tick();
    d_pmem_wdata = '0;
    checks++;
    if (mem_write !== 1 || mem_read !== 0 || mem_wdata !== wd || mem_address !== 32'h0000_2020) begin
      errors++;
      $display("FAIL dwrite_strobe got wr=%0b rd=%0b wdata=%h addr=%h want 1 0 deadbeef 00002020",
               mem_write, mem_read, mem_wdata[31:0], mem_address);
    end
    respond(1, rd);
    d_pmem_write = 0;
  endtask

  task automatic serve_tie(input logic [31:0] ia, input logic [31:0] da);
    logic [255:0] ri = {8{32'h1111_0000 | ia}};
    logic [255:0] rd = {8{32'h2222_0000 | da}};
    tick();
    i_pmem_read = 1;
    i_pmem_address = ia;
    d_pmem_read = 1;
    d_pmem_address = da;
    exp_q.push_back('{1'b0, 1'b0, ia, 256'd0, ri});
    exp_q.push_back('{1'b1, 1'b0, da, 256'd0, rd});
    tick();
    checks++;
    if (mem_read !== 1 || mem_address !== ia) begin
      errors++;
      $display("FAIL tie_first got rd=%0b addr=%h want 1 %h", mem_read, mem_address, ia);
    end
    respond(0, ri);
    i_pmem_read = 0;
    checks++;
    if (mem_read !== 0) begin
      errors++;
      $display("FAIL tie_bubble got rd=%0b want 0", mem_read);
    end
    tick();
    checks++;
    if (mem_read !== 1 || mem_address !== da) begin
      errors++;
      $display("FAIL tie_second got rd=%0b addr=%h want 1 %h", mem_read, mem_address, da);
    end
    respond(0, rd);
    d_pmem_read = 0;
  endtask

  task automatic test_back_to_back();
    serve_tie(32'h0000_3000, 32'h0000_4000);
    serve_tie(32'h0000_5000, 32'h0000_6000);
  endtask

  task automatic test_addr_stability();
    logic [255:0] rd = {16{16'h7E57}};
    tick();
    d_pmem_read = 1;
    d_pmem_address = 32'h0000_7000;
    exp_q.push_back('{1'b1, 1'b0, 32'h0000_7000, 256'd0, rd});
    tick();
    d_pmem_address = 32'hFFFF_FFE0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (mem_address !== 32'h0000_7000 || mem_read !== 1) begin
        errors++;
        $display("FAIL addr_stable got addr=%h rd=%0b want 00007000 1", mem_address, mem_read);
      end
    end
    respond(0, rd);
    d_pmem_read = 0;
  endtask

  task automatic test_stray_resp();
    tick();
    mem_rdata = {8{32'hBAD0_BAD0}};
    mem_resp = 1;
    #1;
    checks++;
    if (i_pmem_resp !== 0 || d_pmem_resp !== 0 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
      errors++;
      $display("FAIL stray_resp got i=%0b d=%0b want 0 0", i_pmem_resp, d_pmem_resp);
    end
    tick();
    mem_resp = 0;
    mem_rdata = '0;
    checks++;
    if (mem_read !== 0 || mem_write !== 0 || mem_address !== '0) begin
      errors++;
      $display("FAIL stray_idle got rd=%0b wr=%0b addr=%h want 0 0 0", mem_read, mem_write, mem_address);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    d_pmem_write = 1;
    d_pmem_address = 32'h0000_8000;
    d_pmem_wdata = {8{32'hCAFE_F00D}};
    tick();
    checks++;
    if (mem_write !== 1) begin
      errors++;
      $display("FAIL rstmid_serve got wr=%0b want 1", mem_write);
    end
    rst = 1;
    tick();
    mem_resp = 1;
    mem_rdata = {8{32'h0BAD_0BAD}};
    #1;
    checks++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || mem_address !== '0 ||
        mem_wdata !== '0 || d_pmem_rdata !== '0 || i_pmem_rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got rd=%0b wr=%0b dresp=%0b addr=%h want all 0",
               mem_read, mem_write, d_pmem_resp, mem_address);
    end
    rst = 0;
    d_pmem_write = 0;
    d_pmem_wdata = '0;
    tick();
    mem_resp = 0;
    mem_rdata = '0;
    serve_tie(32'h0000_9000, 32'h0000_A000);
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_back_to_back();
    test_addr_stability();
    test_stray_resp();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
